apb_m_if: RTL
=============

# apb_m_if

APB requester that turns a simple valid/ready command port into APB transfers and drives the `apb_s_if` completer on the same `pclk` domain. Each accepted command runs one APB transfer through the SETUP and ACCESS phases. The block waits out completer wait states on `pready` and returns one response pulse carrying read data. It is the bus-side front end for any local controller that needs register access to APB completers.

## Interface
Parameters:
- `ADDR_W`, 32, width of `paddr` and `cmd_addr`
- `DATA_W`, 32, width of the write and read data paths
- `TIMEOUT_CYC`, 16, number of ACCESS cycles with `pready` low before the transfer is aborted (used only with `APB_M_TIMEOUT_EN`)

Ports:
- `pclk`  in  1  sole clock; all logic updates on its rising edge
- `preset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  a command is presented
- `cmd_ready`  out  1  block can accept a command this cycle
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  transfer address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DATA_W  read data; 0 for writes
- `rsp_err`  out  1  transfer aborted by timeout (qualified by `rsp_valid`)
- `paddr`  out  ADDR_W  APB address
- `pwrite`  out  1  APB direction
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `pwdata`  out  DATA_W  APB write data
- `prdata`  in  DATA_W  APB read data
- `pready`  in  1  APB completer ready

## Operation
- One clock and one reset. Reset is synchronous and active-high: `preset` is sampled on the `pclk` rising edge.
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`: register `cmd_addr`, `cmd_write` and `cmd_wdata` into `paddr`, `pwrite` and `pwdata`, then go to SETUP.
- **SETUP**
  - `psel` = 1, `penable` = 0, `cmd_ready` = 0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `psel` = 1, `penable` = 1.
  - With `pready` = 0, stay in ACCESS.
  - With `pready` = 1, complete the transfer and go to IDLE:
    - a read captures `prdata` into `rsp_rdata`;
    - a write loads 0 into `rsp_rdata`;
    - `rsp_valid` pulses for the next cycle with `rsp_err` = 0.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the last ACCESS cycle. They keep their values while in IDLE until the next accept.
- `psel` and `penable` are registered outputs decoded from the next state, so they are glitch-free.
- `rsp_valid` has no backpressure. A new command may be accepted in the same cycle that `rsp_valid` is high.
- Commands presented while `cmd_ready` = 0 are neither accepted nor lost. The source holds them per valid/ready rules.

## Timing
- Reset values: `cmd_ready` = 1 (IDLE). All of `psel`, `penable`, `pwrite`, `rsp_valid` and `rsp_err` = 0. `paddr`, `pwdata` and `rsp_rdata` = 0.
- Accept edge k: SETUP is cycle k+1 and ACCESS starts at cycle k+2.
- Zero wait states (`pready` = 1 in the first ACCESS cycle): `rsp_valid` is high in cycle k+3.
- Each wait cycle adds one cycle of latency.
- Minimum spacing between transfers is 3 cycles: SETUP, ACCESS, IDLE. There is always at least one IDLE cycle with `psel` = 0 between transfers.
- `pready` is ignored outside ACCESS.
- Reset during SETUP or ACCESS: on the next edge the FSM returns to IDLE and `psel`/`penable` drop to 0. The in-flight response is discarded (no `rsp_valid`).
- Reset has priority over a simultaneous `cmd_valid` or `pready`.

## Configuration
- Macro `APB_M_TIMEOUT_EN`.
- **Defined:**
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to ACCESS and increments on each ACCESS cycle with `pready` = 0.
  - When the count reaches `TIMEOUT_CYC` with `pready` still 0, the FSM goes to IDLE and `psel`/`penable` drop.
  - `rsp_valid` pulses with `rsp_err` = 1 and `rsp_rdata` = 0.
  - `pready` = 1 on the same cycle the count reaches `TIMEOUT_CYC` is a normal completion, not an error.
- **Undefined:**
  - No counter is built and ACCESS waits indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- Reset: hold `preset` = 1 for 3 cycles -> all outputs at their reset values, `cmd_ready` = 1.
- Zero-wait write: `cmd_addr` = 0x10, `cmd_wdata` = 0xDEADBEEF, `pready` held 1 ->
  - `psel` = 1 for 2 cycles, `penable` = 1 for 1 cycle;
  - `paddr`/`pwdata` stable for both cycles;
  - `rsp_valid` at k+3 with `rsp_rdata` = 0, `rsp_err` = 0.
- Read with 3 wait states: `prdata` = 0x12345678 presented with `pready` = 1 in the 4th ACCESS cycle -> `rsp_valid` at k+6 with `rsp_rdata` = 0x12345678.
- Back-to-back: `cmd_valid` held with 4 queued commands, `pready` = 1 ->
  - accepts occur every 3 cycles;
  - exactly one `psel` = 0 cycle between transfers;
  - 4 `rsp_valid` pulses in order.
- Reset mid-ACCESS: assert `preset` while `pready` = 0 -> `psel`/`penable` = 0 at the next edge, no `rsp_valid`, `cmd_ready` = 1.
- With `APB_M_TIMEOUT_EN`, `TIMEOUT_CYC` = 4: hold `pready` = 0 -> abort after 4 ACCESS cycles, with `rsp_valid` = 1, `rsp_err` = 1 and `rsp_rdata` = 0.

Source files
------------

// File: rtl/apb_m_if_if.sv
// apb_m_if_if: bundle of the command/response port and the APB bus pins
// around the apb_m_if requester.
//   master : the requester's view (drives cmd_ready, rsp_*, paddr, pwrite,
//            psel, penable, pwdata; samples cmd_*, prdata, pready)
//   slave  : the opposite side (command source plus APB completer)
interface apb_m_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwrite, psel, penable, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwrite, psel, penable, pwdata
  );
endinterface

// File: rtl/apb_m_if.sv
// apb_m_if: APB requester. Accepts one valid/ready command at a time and runs
// it as a single APB transfer (SETUP then ACCESS), waiting on pready, and
// returns a one-cycle rsp_valid pulse carrying read data (0 for writes).
// Ports:
//   pclk   : sole clock, rising edge
//   preset : synchronous active-high reset
//   bus    : apb_m_if_if.master (cmd_*, rsp_*, APB pins)
// Optional feature: define APB_M_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYC cycles of pready low; the abort returns rsp_err = 1.
// Without it ACCESS waits forever and rsp_err is tied low.
module apb_m_if #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          pclk,
  input  logic          preset,
  apb_m_if_if.master    bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_M_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Abort fires on the ACCESS cycle whose low pready would bring the count
  // to TIMEOUT_CYC, i.e. after exactly TIMEOUT_CYC stalled ACCESS cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_M_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_M_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (bus.pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
        end
`ifdef APB_M_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // Bus strobes and ready come from the next state so they leave a flop.
    psel_d      = (state_d != IDLE);
    penable_d   = (state_d == ACCESS);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_M_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_M_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
`ifdef APB_M_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule
